uart_multi_ram_bridge: RTL
==========================

UART_MULTI_RAM_BRIDGE -- requirements
Module: uart_multi_ram_bridge

Interface
REQ-001 Parameter NUM_ADDR_BYTES, default 2: address bytes per frame, MSB first.
REQ-002 Parameter RAM_ADDR_BITS, default 12: memory address width; must be <= NUM_ADDR_BYTES*8.
REQ-003 Parameter NUM_SLAVES, default 4: number of memory channels.
REQ-004 Parameter BASE_SLAVE_ID, default 1: slave_id of channel 0; channel k = BASE_SLAVE_ID+k.
REQ-005 Port clk  input  1: single clock for all logic.
REQ-006 Port rst  input  1: asynchronous, active-high reset.
REQ-007 Port rx_data_out  input  8: received UART byte.
REQ-008 Port rx_data_valid  input  1: one-cycle strobe qualifying rx_data_out.
REQ-009 Port rx_block_timeout  input  1: one-cycle strobe marking end of an rx burst.
REQ-010 Port tx_bsy  input  1: transmitter busy; rises the cycle after tx_trig.
REQ-011 Port tx_trig  output  1: one-cycle send request.
REQ-012 Port send_data  output  8: byte to transmit; held stable from tx_trig until tx_bsy falls.
REQ-013 Port mem_address  output  RAM_ADDR_BITS: shared address to all channels.
REQ-014 Port mem_write_data  output  8: shared write data.
REQ-015 Port mem_write_enable  output  NUM_SLAVES: one-hot per-channel write strobe.
REQ-016 Port mem_read_enable  output  NUM_SLAVES: one-hot per-channel read strobe.
REQ-017 Port mem_read_data  input  NUM_SLAVES*8: channel k data in bits [8k+7:8k], valid one cycle after its read strobe.
REQ-018 Port bad_slave  output  1: sticky flag, set by any frame addressing an unmapped slave_id.

Function
REQ-019 The first byte of a frame SHALL be {rnw, slave_id[6:0]}; the next NUM_ADDR_BYTES bytes SHALL load the start address, MSB first; only the low RAM_ADDR_BITS are used.
REQ-020 States SHALL be IDLE, ADDR, WR_DATA, RD_LEN, RD_ECHO, RD_REQ, RD_WAIT, RD_SEND, RD_HOLD.
REQ-021 Write (rnw=0): ADDR -> WR_DATA; each valid data byte SHALL assert exactly one mem_write_enable bit for one cycle in the cycle after rx_data_valid, then increment the address.
REQ-022 Read (rnw=1): ADDR -> RD_LEN; the length byte L SHALL request L+1 data bytes (1..256).
REQ-023 RD_ECHO SHALL transmit {1'b1, slave_id} before any data byte.
REQ-024 Per data byte: RD_REQ asserts one read strobe; RD_WAIT captures the selected channel's mem_read_data; RD_SEND pulses tx_trig when tx_bsy=0; RD_HOLD waits for tx_bsy to fall, then increments the address and either loops to RD_REQ or returns to IDLE after the last byte.
REQ-025 The address SHALL wrap from 2^RAM_ADDR_BITS-1 to 0 in both directions of traffic.
REQ-026 An unmapped slave_id SHALL produce no memory strobes and SHALL set bad_slave; reads SHALL still echo and send L+1 bytes of 0x00.
REQ-027 rx_block_timeout in ADDR, RD_LEN or WR_DATA SHALL return the FSM to IDLE; a write frame ends only by timeout.
REQ-028 rx_data_valid in RD_ECHO through RD_HOLD SHALL be ignored; rx_block_timeout there SHALL be ignored.
REQ-029 If rx_data_valid and rx_block_timeout coincide, the byte SHALL be processed first, then the state returns to IDLE.
REQ-030 tx_trig SHALL never assert while tx_bsy=1.

Reset
REQ-031 rst SHALL force state IDLE and clear address, counters, bad_slave, tx_trig, send_data, mem_address, mem_write_data, mem_write_enable and mem_read_enable to 0, including mid-frame.
REQ-032 After rst deasserts, the next rx byte SHALL be treated as a frame header.

Structure
REQ-033 The state enum and the header bit position (RNW_BIT=7) SHALL live in a shared package uart_bridge_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; channel decode is (slave_id - BASE_SLAVE_ID) < NUM_SLAVES.

Verification
REQ-035 Write: bytes 0x01,0x00,0x10,0xAA,0xBB, then timeout -> ch0 writes 0xAA@0x010 and 0xBB@0x011, then IDLE.
REQ-036 Read: bytes 0x82,0x00,0x20,0x01 with ch1 holding 0x55@0x020 and 0x66@0x021 -> tx sequence 0x82,0x55,0x66.
REQ-037 Wrap: write to ch0 at 0x0FFF with 2 bytes -> writes land at 0x0FFF then 0x000.
REQ-038 Bad slave: bytes 0x85,0x00,0x00,0x00 -> tx 0x85,0x00; no strobes; bad_slave=1.
REQ-039 Slow tx: hold tx_bsy high 100 cycles per byte during a 4-byte read -> exactly 5 tx_trig pulses, none while tx_bsy=1.
REQ-040 Reset mid-read after the echo byte -> all outputs 0; a following write frame completes correctly.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART multi-RAM bridge.
//   RNW_BIT       : header bit selecting read (1) or write (0)
//   SLAVE_ID_BITS : width of the slave_id field in the header byte
//   state_e       : bridge frame-parser / read-sequencer states
package uart_bridge_pkg;

  localparam int unsigned RNW_BIT       = 7;
  localparam int unsigned SLAVE_ID_BITS = 7;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    WR_DATA,
    RD_LEN,
    RD_ECHO,
    RD_REQ,
    RD_WAIT,
    RD_SEND,
    RD_HOLD
  } state_e;

endpackage

// File: rtl/uart_multi_ram_bridge.sv
// UART frame to multi-channel RAM bridge.
// Frame: {rnw, slave_id[6:0]}, NUM_ADDR_BYTES address bytes (MSB first), then
//   write: data bytes until rx_block_timeout, one channel write per byte
//   read : one length byte L; replies echo {1, slave_id} then L+1 data bytes
// Ports:
//   clk, rst (async, active high)
//   rx_data_out/rx_data_valid/rx_block_timeout : UART receive side
//   tx_bsy (in), tx_trig/send_data (out)        : UART transmit side
//   mem_address/mem_write_data                  : shared to all channels
//   mem_write_enable/mem_read_enable            : one-hot per channel
//   mem_read_data                               : channel k in [8k+7:8k], 1-cycle latency
//   bad_slave                                   : sticky unmapped-slave flag
module uart_multi_ram_bridge #(
  parameter int NUM_ADDR_BYTES = 2,
  parameter int RAM_ADDR_BITS  = 12,
  parameter int NUM_SLAVES     = 4,
  parameter int BASE_SLAVE_ID  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data_out,
  input  logic                      rx_data_valid,
  input  logic                      rx_block_timeout,
  input  logic                      tx_bsy,
  output logic                      tx_trig,
  output logic [7:0]                send_data,
  output logic [RAM_ADDR_BITS-1:0]  mem_address,
  output logic [7:0]                mem_write_data,
  output logic [NUM_SLAVES-1:0]     mem_write_enable,
  output logic [NUM_SLAVES-1:0]     mem_read_enable,
  input  logic [NUM_SLAVES*8-1:0]   mem_read_data,
  output logic                      bad_slave
);

  import uart_bridge_pkg::*;

  state_e                     state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [7:0]                 len_q, len_d;
  logic [SLAVE_ID_BITS-1:0]   slave_q, slave_d;
  logic                       rnw_q, rnw_d;
  logic [NUM_SLAVES-1:0]      sel_q, sel_d;
  logic                       echo_sent_q, echo_sent_d;
  logic                       bad_slave_q, bad_slave_d;
  logic                       tx_trig_q, tx_trig_d;
  logic [7:0]                 send_data_q, send_data_d;
  logic [RAM_ADDR_BITS-1:0]   mem_address_q, mem_address_d;
  logic [7:0]                 mem_write_data_q, mem_write_data_d;
  logic [NUM_SLAVES-1:0]      mem_we_q, mem_we_d;
  logic [NUM_SLAVES-1:0]      mem_re_q, mem_re_d;

  logic [NUM_SLAVES-1:0]      hdr_sel;
  logic [7:0]                 rd_byte;

  // Channel decode of the incoming header; all-zero means unmapped.
  always_comb begin
    hdr_sel = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      hdr_sel[k] = (32'(rx_data_out[SLAVE_ID_BITS-1:0]) == 32'(BASE_SLAVE_ID) + k);
    end
  end

  // Read-data mux; an unmapped slave (sel_q all zero) yields 0x00.
  always_comb begin
    rd_byte = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q[k]) rd_byte = mem_read_data[k*8 +: 8];
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    slave_d          = slave_q;
    rnw_d            = rnw_q;
    sel_d            = sel_q;
    echo_sent_d      = echo_sent_q;
    bad_slave_d      = bad_slave_q;
    tx_trig_d        = 1'b0;
    send_data_d      = send_data_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_we_d         = '0;
    mem_re_d         = '0;

    case (state_q)
      IDLE: begin
        if (rx_data_valid) begin
          rnw_d   = rx_data_out[RNW_BIT];
          slave_d = rx_data_out[SLAVE_ID_BITS-1:0];
          sel_d   = hdr_sel;
          addr_d  = '0;
          cnt_d   = '0;
          if (hdr_sel == '0) bad_slave_d = 1'b1;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (rx_data_valid) begin
          // Shift in MSB first; bits above RAM_ADDR_BITS fall off the top.
          addr_d = (addr_q << 8) | RAM_ADDR_BITS'(rx_data_out);
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'(NUM_ADDR_BYTES - 1)) begin
            state_d = rnw_q ? RD_LEN : WR_DATA;
          end
        end
      end

      WR_DATA: begin
        if (rx_data_valid) begin
          mem_we_d         = sel_q;
          mem_address_d    = addr_q;
          mem_write_data_d = rx_data_out;
          addr_d           = addr_q + RAM_ADDR_BITS'(1);
        end
      end

      RD_LEN: begin
        if (rx_data_valid) begin
          len_d       = rx_data_out;
          echo_sent_d = 1'b0;
          state_d     = RD_ECHO;
        end
      end

      RD_ECHO: begin
        if (!echo_sent_q) begin
          if (!tx_bsy) begin
            tx_trig_d   = 1'b1;
            send_data_d = {1'b1, slave_q};
            echo_sent_d = 1'b1;
          end
        end else if (!tx_trig_q && !tx_bsy) begin
          state_d = RD_REQ;
        end
      end

      RD_REQ:  state_d = RD_WAIT;

      RD_WAIT: begin
        send_data_d = rd_byte;
        state_d     = RD_SEND;
      end

      RD_SEND: begin
        if (!tx_bsy) begin
          tx_trig_d = 1'b1;
          state_d   = RD_HOLD;
        end
      end

      RD_HOLD: begin
        // tx_bsy only rises the cycle after tx_trig, so the trigger cycle
        // itself must not be mistaken for the transmitter going idle.
        if (!tx_trig_q && !tx_bsy) begin
          addr_d = addr_q + RAM_ADDR_BITS'(1);
          if (len_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            len_d   = len_q - 8'd1;
            state_d = RD_REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Read strobe is registered on entry so it is visible during RD_REQ and
    // the channel data arrives in RD_WAIT.
    if (state_d == RD_REQ && state_q != RD_REQ) begin
      mem_re_d      = sel_q;
      mem_address_d = addr_d;
    end

    // Any byte in this cycle has been handled above; timeout then wins.
    if (rx_block_timeout &&
        (state_q == IDLE || state_q == ADDR || state_q == WR_DATA || state_q == RD_LEN)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      cnt_q            <= '0;
      len_q            <= '0;
      slave_q          <= '0;
      rnw_q            <= 1'b0;
      sel_q            <= '0;
      echo_sent_q      <= 1'b0;
      bad_slave_q      <= 1'b0;
      tx_trig_q        <= 1'b0;
      send_data_q      <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_we_q         <= '0;
      mem_re_q         <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      cnt_q            <= cnt_d;
      len_q            <= len_d;
      slave_q          <= slave_d;
      rnw_q            <= rnw_d;
      sel_q            <= sel_d;
      echo_sent_q      <= echo_sent_d;
      bad_slave_q      <= bad_slave_d;
      tx_trig_q        <= tx_trig_d;
      send_data_q      <= send_data_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_we_q         <= mem_we_d;
      mem_re_q         <= mem_re_d;
    end
  end

  assign tx_trig          = tx_trig_q;
  assign send_data        = send_data_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_enable  = mem_re_q;
  assign bad_slave        = bad_slave_q;

endmodule
